onchip_mem_arbiter: RTL and testbench

ONCHIP_MEM_ARBITER -- requirements
Module: onchip_mem_arbiter

---
 rtl/onchip_arb_pkg.sv | 20 ++
 rtl/onchip_arb_grant.sv | 77 +++++++
 rtl/onchip_mem_arbiter.sv | 113 +++++++++++
 tb/tb_onchip_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_arb_pkg.sv
// ============================================================================
// Module      : onchip_arb_pkg
// Description : Shared defaults and owner encoding for the on-chip memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package onchip_arb_pkg;

    localparam int c_DEPTH    = 5120;
    localparam int c_ADDR_W   = 13;
    localparam int c_DATA_W   = 32;
    localparam int c_MAX_HOLD = 8;

    localparam logic OWN_M0 = 1'b0;
    localparam logic OWN_M1 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/onchip_arb_grant.sv
// ============================================================================
// Module      : onchip_arb_grant
// Description : Two-master round-robin grant with bounded lock hold.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module onchip_arb_grant
    import onchip_arb_pkg::*;
#(
    parameter int MAX_HOLD = c_MAX_HOLD
) (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic lock0,
    input  logic lock1,
    output logic gnt,
    output logic accept
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic              r_last_grant;
    logic              r_lock_active;
    logic [HOLD_W-1:0] r_hold_cnt;

    logic w_req_last;
    logic w_req_other;
    logic w_hold_full;
    logic w_lock;

    assign w_req_last  = r_last_grant ? req1 : req0;
    assign w_req_other = r_last_grant ? req0 : req1;
    assign w_hold_full = (r_hold_cnt >= HOLD_W'(MAX_HOLD));

    always_comb begin
        gnt = OWN_M0;
        if (r_lock_active) begin
            // The lock holder keeps priority until it idles or exhausts its hold budget.
            if (w_req_other && (!w_req_last || w_hold_full)) begin
                gnt = ~r_last_grant;
            end else begin
                gnt = r_last_grant;
            end
        end else if (req0 && req1) begin
            gnt = ~r_last_grant;
        end else begin
            gnt = req1 ? OWN_M1 : OWN_M0;
        end
    end

    assign accept = (req0 | req1) & ~reset;
    assign w_lock = (gnt == OWN_M1) ? lock1 : lock0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant  <= OWN_M1;
            r_lock_active <= 1'b0;
            r_hold_cnt    <= '0;
        end else if (accept) begin
            r_last_grant  <= gnt;
            r_lock_active <= w_lock;
            if (!w_lock) begin
                r_hold_cnt <= '0;
            end else if (r_lock_active && (gnt == r_last_grant)) begin
                r_hold_cnt <= w_hold_full ? r_hold_cnt : r_hold_cnt + 1'b1;
            end else begin
                r_hold_cnt <= HOLD_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/onchip_mem_arbiter.sv
// ============================================================================
// Module      : onchip_mem_arbiter
// Description : Two-master arbiter in front of a single-port on-chip memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module onchip_mem_arbiter
    import onchip_arb_pkg::*;
#(
    parameter int DEPTH    = c_DEPTH,
    parameter int ADDR_W   = c_ADDR_W,
    parameter int DATA_W   = c_DATA_W,
    parameter int MAX_HOLD = c_MAX_HOLD
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic                m0_lock,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic                m1_lock,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata,
    output logic                err_oor
);

    logic              w_gnt;
    logic              w_accept;
    logic              w_write;
    logic              w_in_range;
    logic              w_ret;
    logic [DATA_W-1:0] w_ret_data;

    logic r_rd_pend;
    logic r_rd_owner;
    logic r_rd_oor;
    logic r_err_oor;

    onchip_arb_grant #(
        .MAX_HOLD(MAX_HOLD)
    ) u_grant (
        .clk    (clk),
        .reset  (reset),
        .req0   (m0_read | m0_write),
        .req1   (m1_read | m1_write),
        .lock0  (m0_lock),
        .lock1  (m1_lock),
        .gnt    (w_gnt),
        .accept (w_accept)
    );

    // Write wins when a master strobes read and write together.
    assign w_write        = (w_gnt == OWN_M1) ? m1_write : m0_write;
    assign mem_address    = (w_gnt == OWN_M1) ? m1_address : m0_address;
    assign mem_byteenable = (w_gnt == OWN_M1) ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = (w_gnt == OWN_M1) ? m1_writedata : m0_writedata;
    assign w_in_range     = ({1'b0, mem_address} < (ADDR_W + 1)'(DEPTH));

    assign mem_chipselect = w_accept & w_in_range;
    assign mem_write      = w_accept & w_in_range & w_write;
    assign mem_clken      = ~reset;

    assign m0_waitrequest = ~(w_accept & (w_gnt == OWN_M0));
    assign m1_waitrequest = ~(w_accept & (w_gnt == OWN_M1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_pend  <= 1'b0;
            r_rd_owner <= OWN_M0;
            r_rd_oor   <= 1'b0;
            r_err_oor  <= 1'b0;
        end else begin
            r_rd_pend  <= w_accept & ~w_write;
            r_rd_owner <= w_gnt;
            r_rd_oor   <= ~w_in_range;
            if (w_accept && !w_in_range) begin
                r_err_oor <= 1'b1;
            end
        end
    end

    // Gating with reset kills a return whose read was accepted just before reset.
    assign w_ret      = r_rd_pend & ~reset;
    assign w_ret_data = r_rd_oor ? '0 : mem_readdata;

    assign m0_readdatavalid = w_ret & (r_rd_owner == OWN_M0);
    assign m1_readdatavalid = w_ret & (r_rd_owner == OWN_M1);
    assign m0_readdata      = m0_readdatavalid ? w_ret_data : '0;
    assign m1_readdata      = m1_readdatavalid ? w_ret_data : '0;
    assign err_oor          = r_err_oor;

endmodule

`default_nettype wire

// File: tb/tb_onchip_mem_arbiter.sv
// ============================================================================
// Module      : tb_onchip_mem_arbiter
// Description : Directed scoreboard bench for the two-master memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_onchip_mem_arbiter;

    localparam int DEPTH = 5120;

    typedef struct {
        logic        own;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd [2];
    logic        wr [2];
    logic        lk [2];
    logic [12:0] ad [2];
    logic [3:0]  be [2];
    logic [31:0] wd [2];
    int          remain [2];

    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [12:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_readdata;
    logic        err_oor;

    logic [31:0] mem [0:DEPTH-1];
    bit          mem_inited;
    logic [31:0] shadow [0:DEPTH-1];

    exp_t        sbq [$];
    int          glog [$];
    bit          acc [2];
    logic        err_exp;
    logic [31:0] last_ret;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    onchip_mem_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .m0_address       (ad[0]),
        .m0_byteenable    (be[0]),
        .m0_read          (rd[0]),
        .m0_write         (wr[0]),
        .m0_writedata     (wd[0]),
        .m0_lock          (lk[0]),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (ad[1]),
        .m1_byteenable    (be[1]),
        .m1_read          (rd[1]),
        .m1_write         (wr[1]),
        .m1_writedata     (wd[1]),
        .m1_lock          (lk[1]),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_writedata    (mem_writedata),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata),
        .err_oor          (err_oor)
    );

    // Single-port memory with one cycle of read latency.
    always @(posedge clk) begin
        logic [31:0] tmp;
        if (!mem_inited) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            mem_inited <= 1'b1;
        end else if (mem_chipselect && (mem_address < 13'(DEPTH))) begin
            if (mem_write) begin
                tmp = mem[mem_address];
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) tmp[8*b +: 8] = mem_writedata[8*b +: 8];
                mem[mem_address] <= tmp;
            end else begin
                mem_readdata <= mem[mem_address];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic [31:0] m_rdata [2];
        logic        m_valid [2];
        logic        m_wait  [2];
        exp_t        e;
        int          n;
        logic [31:0] tmp;
        @(negedge clk);
        m_rdata[0] = m0_readdata;      m_rdata[1] = m1_readdata;
        m_valid[0] = m0_readdatavalid; m_valid[1] = m1_readdatavalid;
        m_wait[0]  = m0_waitrequest;   m_wait[1]  = m1_waitrequest;
        chk("clken", mem_clken, !reset);
        acc[0] = 1'b0;
        acc[1] = 1'b0;
        if (reset) begin
            chk("rst_wait0", m0_waitrequest, 1);
            chk("rst_wait1", m1_waitrequest, 1);
            chk("rst_valid0", m0_readdatavalid, 0);
            chk("rst_valid1", m1_readdatavalid, 0);
            chk("rst_cs", mem_chipselect, 0);
            chk("rst_we", mem_write, 0);
            sbq.delete();
        end else begin
            for (int k = 0; k < 2; k++) begin
                acc[k] = (rd[k] | wr[k]) & !m_wait[k];
                if (!(rd[k] | wr[k])) chk("idle_wait", m_wait[k], 1);
            end
            chk("one_accept", acc[0] & acc[1], 0);
            chk("err_oor", err_oor, err_exp);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("ret_valid", m_valid[e.own], 1);
                chk("ret_data", m_rdata[e.own], e.data);
                chk("other_valid", m_valid[!e.own], 0);
                chk("other_data", m_rdata[!e.own], 0);
                last_ret = m_rdata[e.own];
            end else begin
                chk("no_valid0", m0_readdatavalid, 0);
                chk("no_valid1", m1_readdatavalid, 0);
                chk("idle_data", m0_readdata | m1_readdata, 0);
            end
            if (acc[0] || acc[1]) begin
                n = acc[1] ? 1 : 0;
                glog.push_back(n);
                if (ad[n] < 13'(DEPTH)) begin
                    chk("cs", mem_chipselect, 1);
                    chk("we", mem_write, wr[n]);
                    chk("addr", mem_address, ad[n]);
                    if (wr[n]) begin
                        chk("wdata", mem_writedata, wd[n]);
                        chk("be", mem_byteenable, be[n]);
                        tmp = shadow[ad[n]];
                        for (int b = 0; b < 4; b++)
                            if (be[n][b]) tmp[8*b +: 8] = wd[n][8*b +: 8];
                        shadow[ad[n]] = tmp;
                    end else begin
                        sbq.push_back('{own: n[0], data: shadow[ad[n]]});
                    end
                end else begin
                    chk("oor_cs", mem_chipselect, 0);
                    chk("oor_we", mem_write, 0);
                    err_exp = 1'b1;
                    if (!wr[n]) sbq.push_back('{own: n[0], data: 32'h0});
                end
            end else begin
                chk("idle_cs", mem_chipselect, 0);
                chk("idle_we", mem_write, 0);
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (acc[k]) begin
                remain[k]--;
                ad[k] = ad[k] + 13'd1;
                wd[k] = wd[k] + 32'h01010101;
                if (remain[k] <= 0) begin
                    rd[k] = 1'b0;
                    wr[k] = 1'b0;
                    lk[k] = 1'b0;
                end
            end
        end
    endtask

    task automatic issue(input int n, input bit r, input bit w, input logic [12:0] a,
                         input logic [31:0] d, input logic [3:0] b, input bit l, input int cnt);
        rd[n] = r; wr[n] = w; ad[n] = a; wd[n] = d; be[n] = b; lk[n] = l; remain[n] = cnt;
    endtask

    task automatic run(input int limit);
        int c = 0;
        while ((remain[0] > 0 || remain[1] > 0) && c < limit) begin
            cycle();
            c++;
        end
        chk("run_timeout", (remain[0] > 0 || remain[1] > 0), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        err_exp = 1'b0;
        cycle();
    endtask

    initial begin
        int exp_g [$];
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
        for (int k = 0; k < 2; k++) issue(k, 1, 0, '0, '0, '0, 0, 0);
        err_exp  = 1'b0;
        last_ret = '0;

        // Reset with both masters requesting.
        repeat (3) cycle();
        rd[0] = 1'b0; rd[1] = 1'b0;
        reset = 1'b0;
        cycle();
        chk("reset_err", err_oor, 0);

        // Write then read back a full word; read+write together acts as a write.
        issue(0, 0, 1, 13'h10, 32'hDEADBEEF, 4'hF, 0, 1); run(20);
        issue(0, 1, 0, 13'h10, '0, '0, 0, 1); run(20); repeat (2) cycle();
        chk("rd_deadbeef", last_ret, 32'hDEADBEEF);
        issue(0, 1, 1, 13'h20, 32'h12345678, 4'hF, 0, 1); run(20); repeat (2) cycle();
        issue(0, 1, 0, 13'h20, '0, '0, 0, 1); run(20); repeat (2) cycle();
        chk("rdwr_as_write", last_ret, 32'h12345678);

        // Byte-lane merge.
        issue(0, 0, 1, 13'h30, 32'h11223344, 4'hF, 0, 1); run(20);
        issue(0, 0, 1, 13'h30, 32'h0000AB00, 4'h2, 0, 1); run(20);
        issue(0, 1, 0, 13'h30, '0, '0, 0, 1); run(20); repeat (2) cycle();
        chk("byte_lane", last_ret, 32'h1122AB44);

        // Alternating round-robin reads after reset, m0 first.
        issue(0, 0, 1, 13'h100, 32'hA0000000, 4'hF, 0, 6);
        issue(1, 0, 1, 13'h200, 32'hB0000000, 4'hF, 0, 6);
        run(50);
        do_reset();
        glog.delete();
        issue(0, 1, 0, 13'h100, '0, '0, 0, 6);
        issue(1, 1, 0, 13'h200, '0, '0, 0, 6);
        run(50); repeat (2) cycle();
        chk("rr_count", glog.size(), 12);
        for (int i = 0; i < 12 && i < glog.size(); i++) chk("rr_order", glog[i], i % 2);

        // Locked m1 stream bounded by the hold limit.
        glog.delete();
        issue(1, 1, 0, 13'h200, '0, '0, 1, 20);
        cycle();
        issue(0, 1, 0, 13'h100, '0, '0, 0, 3);
        run(100); repeat (2) cycle();
        repeat (8) exp_g.push_back(1); exp_g.push_back(0);
        repeat (8) exp_g.push_back(1); exp_g.push_back(0);
        repeat (4) exp_g.push_back(1); exp_g.push_back(0);
        chk("lock_count", glog.size(), exp_g.size());
        for (int i = 0; i < exp_g.size() && i < glog.size(); i++) chk("lock_order", glog[i], exp_g[i]);

        // Out-of-range write and read, sticky error.
        issue(0, 0, 1, 13'd5120, 32'hCAFEF00D, 4'hF, 0, 1); run(20); cycle();
        chk("oor_err_set", err_oor, 1);
        last_ret = 32'hFFFFFFFF;
        issue(0, 1, 0, 13'd5200, '0, '0, 0, 1); run(20); repeat (2) cycle();
        chk("oor_rd_zero", last_ret, 0);
        repeat (3) cycle();
        chk("oor_err_hold", err_oor, 1);
        do_reset();
        chk("oor_err_clr", err_oor, 0);

        // Reset right after a read is accepted; then m0 wins the first tie.
        issue(0, 1, 0, 13'h10, '0, '0, 0, 1); run(20);
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        cycle();
        glog.delete();
        issue(0, 1, 0, 13'h10, '0, '0, 0, 1);
        issue(1, 1, 0, 13'h20, '0, '0, 0, 1);
        run(20); repeat (2) cycle();
        chk("post_rst_n", glog.size(), 2);
        if (glog.size() >= 2) begin
            chk("post_rst_g0", glog[0], 0);
            chk("post_rst_g1", glog[1], 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
